// File: rtl/uart_receiver_if.sv
// uart_receiver_if
// Groups the serial input line and the received-byte outputs of the UART
// receiver into one bundle.
//   i_rx             serial line into the receiver; idles high
//   o_data[0:7]      last good byte; index 0 holds the first data bit on the wire
//   o_valid          one-cycle pulse; o_data changes in the same cycle
//   o_framing_error  one-cycle pulse; the stop bit was sampled low
//   o_busy           high while a frame is being received
// The receiver uses the master modport because it produces the byte stream.
// The consumer, which also drives the line, uses the slave modport.
interface uart_receiver_if;
   logic       i_rx;
   logic [0:7] o_data;
   logic       o_valid;
   logic       o_framing_error;
   logic       o_busy;

   modport master (
      input  i_rx,
      output o_data,
      output o_valid,
      output o_framing_error,
      output o_busy
   );

   modport slave (
      output i_rx,
      input  o_data,
      input  o_valid,
      input  o_framing_error,
      input  o_busy
   );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
// Recovers 8N1 frames (one start bit, 8 data bits, one stop bit) from an
// asynchronous serial line. A good byte is presented with a one-cycle valid
// pulse. A frame whose stop bit is low produces a one-cycle framing-error
// pulse instead.
// Parameters:
//   CYCLES_PER_SAMPLE  clock cycles per bit (legal range 4..65535)
// Ports:
//   clk      system clock
//   r_reset  synchronous, active-high reset
//   rx_if    uart_receiver_if.master (i_rx, o_data, o_valid,
//            o_framing_error, o_busy)
module uart_receiver #(
   parameter int unsigned CYCLES_PER_SAMPLE = 10416
) (
   input logic             clk,
   input logic             r_reset,
   uart_receiver_if.master rx_if
);

   localparam int unsigned HALF_SAMPLE = CYCLES_PER_SAMPLE >> 1;
   localparam logic [15:0] HALF_LAST   = 16'(HALF_SAMPLE - 1);
   localparam logic [15:0] BIT_LAST    = 16'(CYCLES_PER_SAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic [15:0] count;
   logic [3:0]  bit_idx;
   logic [0:7]  shift_reg;

   // The synchronizer and rx_prev advance every cycle, whatever the state.
   // A start edge that arrives right after the stop-bit sample is therefore
   // still seen from IDLE.
   //
   // Start is detected only on a falling edge. A line held low after a
   // frame (a break) cannot restart the receiver until it goes high again.
   //
   // START waits half a bit period so that every later sample falls near
   // the middle of its bit. A high line at that point is treated as a
   // glitch and dropped silently.
   //
   // o_busy is registered alongside each state change, so it already
   // shows the state being entered.
   always_ff @(posedge clk) begin
      if (r_reset) begin
         state                 <= IDLE;
         rx_s1                 <= 1'b1;
         rx_s2                 <= 1'b1;
         rx_prev               <= 1'b1;
         count                 <= '0;
         bit_idx               <= '0;
         shift_reg             <= '0;
         rx_if.o_data          <= '0;
         rx_if.o_valid         <= 1'b0;
         rx_if.o_framing_error <= 1'b0;
         rx_if.o_busy          <= 1'b0;
      end else begin
         rx_s1                 <= rx_if.i_rx;
         rx_s2                 <= rx_s1;
         rx_prev               <= rx_s2;
         rx_if.o_valid         <= 1'b0;
         rx_if.o_framing_error <= 1'b0;

         case (state)
            IDLE: begin
               count <= '0;
               if (rx_prev && !rx_s2) begin
                  state        <= START;
                  rx_if.o_busy <= 1'b1;
               end
            end

            START: begin
               if (count == HALF_LAST) begin
                  count   <= '0;
                  bit_idx <= '0;
                  if (!rx_s2) begin
                     state <= DATA;
                  end else begin
                     state        <= IDLE;
                     rx_if.o_busy <= 1'b0;
                  end
               end else begin
                  count <= count + 16'd1;
               end
            end

            DATA: begin
               if (count == BIT_LAST) begin
                  shift_reg[bit_idx[2:0]] <= rx_s2;
                  bit_idx                 <= bit_idx + 4'd1;
                  count                   <= '0;
                  if (bit_idx == 4'd7) begin
                     state <= STOP;
                  end
               end else begin
                  count <= count + 16'd1;
               end
            end

            STOP: begin
               if (count == BIT_LAST) begin
                  if (rx_s2) begin
                     rx_if.o_data  <= shift_reg;
                     rx_if.o_valid <= 1'b1;
                  end else begin
                     rx_if.o_framing_error <= 1'b1;
                  end
                  state        <= IDLE;
                  rx_if.o_busy <= 1'b0;
                  count        <= '0;
               end else begin
                  count <= count + 16'd1;
               end
            end

            default: begin
               state        <= IDLE;
               rx_if.o_busy <= 1'b0;
               count        <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver with CYCLES_PER_SAMPLE = 16.
// The bench pushes the expected result of each frame (kind, byte and
// arrival cycle) onto a queue as the frame is driven. A monitor pops one
// entry and compares it each time the receiver pulses o_valid or
// o_framing_error.
module tb_uart_receiver;

   localparam int unsigned C       = 16;
   localparam int          LATENCY = 155;

   typedef struct {
      bit         is_error;
      logic [7:0] data;
      int         cycle;
   } expect_t;

   logic            clk;
   logic            r_reset;
   uart_receiver_if rx_if ();

   expect_t    sb_queue[$];
   logic [7:0] last_good;
   int         cyc;
   int         check_count;
   int         fail_count;
   bit         prev_pulse;

   uart_receiver #(.CYCLES_PER_SAMPLE(C)) dut (
      .clk     (clk),
      .r_reset (r_reset),
      .rx_if   (rx_if.master)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running cycle count, used to time-stamp the expected pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Counts one comparison and reports it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Drives one full frame starting at the current negedge and returns on
   // the negedge where the stop bit ends.
   task automatic applyStimulus(input logic [0:7] bits, input logic stop_bit);
      expect_t e;
      e.is_error = !stop_bit;
      e.cycle    = cyc + LATENCY;
      if (stop_bit) last_good = bits;
      e.data = last_good;
      sb_queue.push_back(e);
      rx_if.i_rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_if.i_rx = bits[i];
         repeat (C) @(negedge clk);
      end
      rx_if.i_rx = stop_bit;
      repeat (C) @(negedge clk);
   endtask

   task automatic idleLine(input int n);
      rx_if.i_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: every result pulse must match the oldest pending
   // expectation in kind, byte and arrival cycle.
   always @(negedge clk) begin
      if (!r_reset && (rx_if.o_valid || rx_if.o_framing_error)) begin
         checkOutput("exclusive", {31'b0, rx_if.o_valid & rx_if.o_framing_error}, 32'd0);
         checkOutput("single_cycle_pulse", {31'b0, prev_pulse}, 32'd0);
         if (sb_queue.size() == 0) begin
            checkOutput("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            expect_t e;
            e = sb_queue.pop_front();
            checkOutput("pulse_kind", {31'b0, rx_if.o_framing_error}, {31'b0, e.is_error});
            checkOutput("data", {24'b0, rx_if.o_data}, {24'b0, e.data});
            checkOutput("pulse_cycle", cyc, e.cycle);
         end
      end
      prev_pulse <= rx_if.o_valid | rx_if.o_framing_error;
   end

   // Watchdog: the stimulus is a fixed length, so this fires only if
   // something stalls.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int busy_cycles;
      int wait_cycles;
      logic [0:7] pat;

      cyc         = 0;
      check_count = 0;
      fail_count  = 0;
      prev_pulse  = 1'b0;
      last_good   = 8'h00;
      rx_if.i_rx  = 1'b1;
      r_reset     = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      r_reset = 1'b0;

      // Reset state.
      checkOutput("reset_data", {24'b0, rx_if.o_data}, 32'd0);
      checkOutput("reset_valid", {31'b0, rx_if.o_valid}, 32'd0);
      checkOutput("reset_ferr", {31'b0, rx_if.o_framing_error}, 32'd0);
      checkOutput("reset_busy", {31'b0, rx_if.o_busy}, 32'd0);
      idleLine(10);

      // Single frame with wire bits 1,0,1,0,0,1,0,1.
      applyStimulus(8'b1010_0101, 1'b1);
      idleLine(30);

      // Two frames back to back with no idle gap.
      applyStimulus(8'b1100_1010, 1'b1);
      applyStimulus(8'b0011_1001, 1'b1);
      idleLine(30);

      // Glitch: three low cycles must give an 8-cycle busy window, no pulse.
      busy_cycles = 0;
      rx_if.i_rx  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rx_if.o_busy) busy_cycles++;
         if (i == 2) rx_if.i_rx = 1'b1;
      end
      checkOutput("glitch_busy_cycles", busy_cycles, 32'd8);
      checkOutput("glitch_idle_after", {31'b0, rx_if.o_busy}, 32'd0);

      // Framing error: stop bit low, o_data keeps the previous byte.
      applyStimulus(8'b1111_0000, 1'b0);
      idleLine(30);

      // Break: one framing error, then nothing until the line rises again.
      begin
         expect_t e;
         e.is_error = 1'b1;
         e.data     = last_good;
         e.cycle    = cyc + LATENCY;
         sb_queue.push_back(e);
      end
      rx_if.i_rx = 1'b0;
      repeat (1000) @(negedge clk);
      checkOutput("break_busy_released", {31'b0, rx_if.o_busy}, 32'd0);
      idleLine(20);
      applyStimulus(8'b0110_1101, 1'b1);
      idleLine(30);

      // Reset during data bit 3. Bit 3 is high, so the line is high once
      // reset releases and no spurious start edge is seen.
      pat        = 8'b0101_1010;
      rx_if.i_rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_if.i_rx = pat[i];
         repeat (C) @(negedge clk);
      end
      rx_if.i_rx = pat[3];
      repeat (C / 2) @(negedge clk);
      checkOutput("busy_before_reset", {31'b0, rx_if.o_busy}, 32'd1);
      r_reset = 1'b1;
      @(negedge clk);
      r_reset   = 1'b0;
      last_good = 8'h00;
      checkOutput("busy_after_reset", {31'b0, rx_if.o_busy}, 32'd0);
      idleLine(40);
      checkOutput("data_after_reset", {24'b0, rx_if.o_data}, 32'd0);
      applyStimulus(8'b1001_0011, 1'b1);
      idleLine(30);

      // Allow any remaining expected pulse to arrive, with a bounded wait.
      wait_cycles = 0;
      while (sb_queue.size() != 0 && wait_cycles < 400) begin
         @(negedge clk);
         wait_cycles++;
      end
      checkOutput("pending_results", sb_queue.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: recovers 8N1 frames (one start bit, 8 data bits, one stop bit) from the asynchronous `i_rx` line. Each byte is presented on `o_data` with a one-cycle `o_valid` pulse, and malformed frames raise a framing-error pulse. It is the receive end of the link driven by our `uart_transmitter` and uses the same bit period and data-bit order, so a byte looped through both blocks arrives unchanged.

## Interface
- `CYCLES_PER_SAMPLE`, 10416, clock cycles per bit (100 MHz / 9600 baud); legal range 4..65535.
- `HALF_SAMPLE`, `CYCLES_PER_SAMPLE >> 1`, start-bit midpoint offset (derived, not overridden).

Reset and clock: reset r_reset, synchronous, active-high; clock clk.

- `clk`  in  1  system clock
- `r_reset`  in  1  synchronous active-high reset
- `i_rx`  in  1  asynchronous serial line; idles high
- `o_data`  out  [0:7]  last good byte; first wire data bit at index 0
- `o_valid`  out  1  one-cycle pulse; `o_data` updated in the same cycle
- `o_framing_error`  out  1  one-cycle pulse; stop bit sampled low
- `o_busy`  out  1  high in every state except IDLE

## Operation
- Input path: 2-flop synchronizer on `i_rx` (`rx_s1`, `rx_s2`), plus `rx_prev`, the previous `rx_s2`. A falling edge is `rx_prev == 1 && rx_s2 == 0`.
- 16-bit cycle counter, 4-bit bit index, 8-bit shift register.
- States:
  - IDLE: counter = 0. On a falling edge, go to START.
  - START: increment counter. At count == HALF_SAMPLE-1, sample `rx_s2`.
    - If 0: go to DATA, counter = 0, bit index = 0.
    - If 1: false start; go to IDLE with no output activity.
  - DATA: increment counter. At count == CYCLES_PER_SAMPLE-1, sample `rx_s2` into shift-register index [bit], then bit++ and counter = 0. After bit 7 is sampled, go to STOP.
  - STOP: increment counter. At count == CYCLES_PER_SAMPLE-1, sample `rx_s2`.
    - If 1: load `o_data`, pulse `o_valid`.
    - If 0: pulse `o_framing_error`; `o_data` is unchanged.
    - Either way, go to IDLE.
- Start detection is edge-based only. A line held low (break) produces one framing error, then no new frame until the line returns high and falls again.
- `rx_prev` updates every cycle in every state, so a start edge arriving in the cycle right after the STOP sample is caught.
- Counter arithmetic is 16-bit unsigned. It never exceeds CYCLES_PER_SAMPLE-1, so it never wraps.

## Timing
- Reset (r_reset high at a posedge):
  - State IDLE; counter and bit index = 0.
  - `rx_s1`, `rx_s2`, `rx_prev` = 1.
  - `o_data` = 0x00; `o_valid`, `o_framing_error`, `o_busy` = 0.
  - Reset wins over every other event.
- Reset mid-frame aborts the frame. No `o_valid` or error is produced, and the partial byte is discarded.
- Let posedge k be the first posedge that samples `i_rx` = 0:
  - START is entered at posedge k+2.
  - DATA is entered at posedge k+2+HALF_SAMPLE.
  - STOP is entered at posedge k+2+HALF_SAMPLE+8·C.
  - `o_valid` or `o_framing_error` is high for exactly the cycle after posedge k+2+HALF_SAMPLE+9·C.
  - With C = 16 that is posedge k+154.
- `o_busy` rises at posedge k+2 and falls at the same posedge the result pulse rises.
- `o_valid` and `o_framing_error` are registered, mutually exclusive, and never high for two consecutive cycles.
- `o_data` holds its value between valid pulses.

## Test plan
All scenarios use CYCLES_PER_SAMPLE = 16.
- Single frame: drive start, then data bits 1,0,1,0,0,1,0,1, then stop. Expect `o_data[0:7]` = 1,0,1,0,0,1,0,1 and `o_valid` high for one cycle exactly 154 cycles after the first low sample. `o_framing_error` stays 0.
- Back-to-back: two frames with no idle gap between them. Expect two `o_valid` pulses 160 cycles apart, with correct bytes each time.
- Glitch: drive `i_rx` low for 3 cycles, then high. Expect `o_busy` high for 8 cycles, then IDLE, with no `o_valid` and no error.
- Framing error: send a valid frame whose stop bit is 0. Expect `o_framing_error` high for one cycle at the `o_valid` slot, and `o_data` still holding the previous byte.
- Break: hold `i_rx` low for 1000 cycles. Expect exactly one framing error. After the line goes high, then a good frame, expect `o_valid` with the correct byte.
- Reset mid-frame: assert `r_reset` for 1 cycle during DATA bit 3. Expect `o_busy` = 0 on the next cycle and no pulse. A following frame is received correctly.
